// File: rtl/hazard_ctrl.sv
// Hazard and halt controller for the 16-bit RISC core ID stage.
// Drives PC/IF-ID enables, flushes and ID/EX bubbles, and drains the pipeline on halt.
module hazard_ctrl #(
   parameter int OP_CODE_SIZE  = 4,
   parameter int REG_ADDR_BITS = 3,
   parameter int DRAIN_CYCLES  = 3,
   parameter int CNT_W         = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [OP_CODE_SIZE-1:0]  id_opcode,
   input  logic [REG_ADDR_BITS-1:0] id_rs,
   input  logic [REG_ADDR_BITS-1:0] id_rt,
   input  logic                     id_jump,
   input  logic                     ex_mem_read,
   input  logic [REG_ADDR_BITS-1:0] ex_rt,
   input  logic                     ex_branch_taken,
   input  logic                     halt_req,
   output logic                     pc_write,
   output logic                     if_id_write,
   output logic                     if_id_flush,
   output logic                     id_ex_bubble,
   output logic                     halt_ack,
   output logic [CNT_W-1:0]         stall_cnt,
   output logic [CNT_W-1:0]         flush_cnt,
   output logic [1:0]               state
);

   typedef enum logic [1:0] {
      s_run    = 2'd0,
      s_drain  = 2'd1,
      s_halted = 2'd2,
      s_bad    = 2'd3
   } state_t;

   localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [DW-1:0]           DRAIN_LAST = DW'(DRAIN_CYCLES - 1);
   localparam logic [OP_CODE_SIZE-1:0] OP_LW      = '0;
   localparam logic [OP_CODE_SIZE-1:0] OP_J       = OP_CODE_SIZE'(13);

   state_t         cur_state;
   state_t         next_state;
   logic [DW-1:0]  drain_cnt;
   logic           uses_rs;
   logic           uses_rt;
   logic           lu;
   logic           br;
   logic           stall_evt;

   // Register-use decode: undefined opcodes decode as data processing and read both.
   assign uses_rs = (id_opcode != OP_J);
   assign uses_rt = (id_opcode != OP_J) && (id_opcode != OP_LW);

   assign lu = ex_mem_read &
               (((ex_rt == id_rs) & uses_rs) | ((ex_rt == id_rt) & uses_rt));
   assign br = ex_branch_taken;

   assign state = cur_state;

   // NOTE: every output and next_state is given a default before the case so
   // no path through this block leaves a signal unassigned and infers a latch.
   always_comb begin
      next_state   = cur_state;
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;
      stall_evt    = 1'b0;

      case (cur_state)
         s_drain, s_halted: begin
            // The ID instruction is held so it reissues after the halt ends.
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            if (br) begin
               pc_write    = 1'b1;
               if_id_flush = 1'b1;
            end
            if (cur_state == s_drain) begin
               if (drain_cnt == DRAIN_LAST) next_state = s_halted;
            end else if (!halt_req) begin
               next_state = s_run;
            end
         end

         default: begin
            // RUN and the unreachable encoding share outputs; halt_req only
            // steers next_state here, never the hazard outputs.
            if (br) begin
               if_id_flush  = 1'b1;
               id_ex_bubble = 1'b1;
            end else if (lu) begin
               pc_write     = 1'b0;
               if_id_write  = 1'b0;
               id_ex_bubble = 1'b1;
               stall_evt    = 1'b1;
            end else if (id_jump) begin
               if_id_flush  = 1'b1;
            end

            if (cur_state == s_bad)      next_state = s_run;
            else if (halt_req && !br)    next_state = s_drain;
         end
      endcase

      if (rst) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         if_id_flush  = 1'b0;
         id_ex_bubble = 1'b1;
         stall_evt    = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur_state <= s_run;
         halt_ack  <= 1'b0;
      end else begin
         cur_state <= next_state;
         halt_ack  <= (next_state == s_halted);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         drain_cnt <= '0;
      end else if (cur_state != s_drain) begin
         drain_cnt <= '0;
      end else if (drain_cnt != DRAIN_LAST) begin
         drain_cnt <= drain_cnt + 1'b1;
      end
   end

   // Bring-up event counters saturate rather than wrap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall_evt && (stall_cnt != {CNT_W{1'b1}}))
            stall_cnt <= stall_cnt + 1'b1;
         if (if_id_flush && (flush_cnt != {CNT_W{1'b1}}))
            flush_cnt <= flush_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: hazards, priority, halt handshake, reset and saturation.
module tb_hazard_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  id_opcode = 4'b0010;
   logic [2:0]  id_rs = 3'd1;
   logic [2:0]  id_rt = 3'd2;
   logic        id_jump = 1'b0;
   logic        ex_mem_read = 1'b0;
   logic [2:0]  ex_rt = 3'd0;
   logic        ex_branch_taken = 1'b0;
   logic        halt_req = 1'b0;

   logic        pc_write, if_id_write, if_id_flush, id_ex_bubble, halt_ack;
   logic [15:0] stall_cnt, flush_cnt;
   logic [1:0]  state;

   logic        s_pc_write, s_if_id_write, s_if_id_flush, s_id_ex_bubble, s_halt_ack;
   logic [1:0]  s_stall_cnt, s_flush_cnt;
   logic [1:0]  s_state;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   hazard_ctrl dut (
      .clk(clk), .rst(rst), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
      .id_jump(id_jump), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
      .ex_branch_taken(ex_branch_taken), .halt_req(halt_req),
      .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
      .id_ex_bubble(id_ex_bubble), .halt_ack(halt_ack), .stall_cnt(stall_cnt),
      .flush_cnt(flush_cnt), .state(state)
   );

   // Narrow-counter copy on the same stimulus, used to reach saturation quickly.
   hazard_ctrl #(.CNT_W(2)) sat (
      .clk(clk), .rst(rst), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
      .id_jump(id_jump), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
      .ex_branch_taken(ex_branch_taken), .halt_req(halt_req),
      .pc_write(s_pc_write), .if_id_write(s_if_id_write), .if_id_flush(s_if_id_flush),
      .id_ex_bubble(s_id_ex_bubble), .halt_ack(s_halt_ack), .stall_cnt(s_stall_cnt),
      .flush_cnt(s_flush_cnt), .state(s_state)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic drive(input logic [3:0] op, input logic [2:0] rs, input logic [2:0] rt,
                        input logic jmp, input logic mr, input logic [2:0] ert,
                        input logic brt, input logic hreq);
      id_opcode       = op;
      id_rs           = rs;
      id_rt           = rt;
      id_jump         = jmp;
      ex_mem_read     = mr;
      ex_rt           = ert;
      ex_branch_taken = brt;
      halt_req        = hreq;
      #1;
   endtask

   task automatic check_ctl(input string tag, input logic pw, input logic iw,
                            input logic fl, input logic bb);
      check({tag, ".pc_write"},     {31'd0, pc_write},     {31'd0, pw});
      check({tag, ".if_id_write"},  {31'd0, if_id_write},  {31'd0, iw});
      check({tag, ".if_id_flush"},  {31'd0, if_id_flush},  {31'd0, fl});
      check({tag, ".id_ex_bubble"}, {31'd0, id_ex_bubble}, {31'd0, bb});
   endtask

   initial begin
      // Reset values, including across a clock edge.
      #2;
      check_ctl("reset", 1'b0, 1'b0, 1'b0, 1'b1);
      check("reset.halt_ack", {31'd0, halt_ack}, 32'd0);
      tick();
      check("reset.state", {30'd0, state}, 32'd0);
      check("reset.stall_cnt", {16'd0, stall_cnt}, 32'd0);
      check("reset.flush_cnt", {16'd0, flush_cnt}, 32'd0);
      rst = 1'b0;

      // Plain ADD, no hazard.
      drive(4'b0010, 3'd1, 3'd2, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
      check_ctl("normal", 1'b1, 1'b1, 1'b0, 1'b0);
      tick();

      // Load-use on rs, then the bubble clears ex_mem_read.
      drive(4'b0010, 3'd2, 3'd5, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0);
      check_ctl("lu_rs", 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      check("lu_rs.stall_cnt", {16'd0, stall_cnt}, 32'd1);
      drive(4'b0010, 3'd2, 3'd5, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0);
      check_ctl("lu_after", 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      check("lu_after.stall_cnt", {16'd0, stall_cnt}, 32'd1);

      // Load-use on rt.
      drive(4'b0010, 3'd1, 3'd5, 1'b0, 1'b1, 3'd5, 1'b0, 1'b0);
      check("lu_rt.bubble", {31'd0, id_ex_bubble}, 32'd1);
      tick();
      check("lu_rt.stall_cnt", {16'd0, stall_cnt}, 32'd2);

      // LW in ID: rt unused, no stall.
      drive(4'b0000, 3'd1, 3'd3, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0);
      check_ctl("lw_no_stall", 1'b1, 1'b1, 1'b0, 1'b0);
      tick();

      // J in ID: rs unused, jump flushes IF/ID.
      drive(4'b1101, 3'd3, 3'd3, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0);
      check("j.pc_write", {31'd0, pc_write}, 32'd1);
      check("j.if_id_flush", {31'd0, if_id_flush}, 32'd1);
      check("j.bubble", {31'd0, id_ex_bubble}, 32'd0);
      tick();
      check("j.flush_cnt", {16'd0, flush_cnt}, 32'd1);
      check("j.stall_cnt", {16'd0, stall_cnt}, 32'd2);

      // SW, undefined 1111 and BNE all read rt.
      drive(4'b0001, 3'd0, 3'd4, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0);
      check("sw_rt.bubble", {31'd0, id_ex_bubble}, 32'd1);
      tick();
      drive(4'b1111, 3'd0, 3'd6, 1'b0, 1'b1, 3'd6, 1'b0, 1'b0);
      check("undef_rt.pc_write", {31'd0, pc_write}, 32'd0);
      tick();
      drive(4'b1100, 3'd0, 3'd7, 1'b0, 1'b1, 3'd7, 1'b0, 1'b0);
      check("bne_rt.if_id_write", {31'd0, if_id_write}, 32'd0);
      tick();
      check("rt_users.stall_cnt", {16'd0, stall_cnt}, 32'd5);

      // Taken branch beats load-use.
      drive(4'b0010, 3'd2, 3'd5, 1'b0, 1'b1, 3'd2, 1'b1, 1'b0);
      check("prio.pc_write", {31'd0, pc_write}, 32'd1);
      check("prio.if_id_flush", {31'd0, if_id_flush}, 32'd1);
      check("prio.bubble", {31'd0, id_ex_bubble}, 32'd1);
      tick();
      check("prio.flush_cnt", {16'd0, flush_cnt}, 32'd2);
      check("prio.stall_cnt", {16'd0, stall_cnt}, 32'd5);

      // Halt handshake: halt_req does not touch RUN outputs.
      drive(4'b0010, 3'd1, 3'd2, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
      check_ctl("halt_run", 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      check("halt.e1.state", {30'd0, state}, 32'd1);
      check_ctl("drain", 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      check("halt.e2.state", {30'd0, state}, 32'd1);
      tick();
      check("halt.e3.state", {30'd0, state}, 32'd1);
      check("halt.e3.ack", {31'd0, halt_ack}, 32'd0);
      tick();
      check("halt.e4.state", {30'd0, state}, 32'd2);
      check("halt.e4.ack", {31'd0, halt_ack}, 32'd1);
      drive(4'b0010, 3'd1, 3'd2, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
      check_ctl("halted", 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      check("resume.state", {30'd0, state}, 32'd0);
      check("resume.ack", {31'd0, halt_ack}, 32'd0);
      check_ctl("resume", 1'b1, 1'b1, 1'b0, 1'b0);

      // Branch in first DRAIN cycle, then halt_req dropped mid-drain.
      drive(4'b0010, 3'd1, 3'd2, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
      tick();
      drive(4'b0010, 3'd1, 3'd2, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1);
      check_ctl("drain_br", 1'b1, 1'b0, 1'b1, 1'b1);
      tick();
      check("drain_br.flush_cnt", {16'd0, flush_cnt}, 32'd3);
      drive(4'b0010, 3'd1, 3'd2, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
      check_ctl("drain_nobr", 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      check("abort.e3.state", {30'd0, state}, 32'd1);
      tick();
      check("abort.e4.ack", {31'd0, halt_ack}, 32'd1);
      tick();
      check("abort.e5.state", {30'd0, state}, 32'd0);
      check("abort.e5.ack", {31'd0, halt_ack}, 32'd0);

      // Asynchronous reset while HALTED.
      drive(4'b0010, 3'd1, 3'd2, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
      repeat (4) tick();
      check("pre_rst.ack", {31'd0, halt_ack}, 32'd1);
      rst = 1'b1;
      #1;
      check("rst_async.ack", {31'd0, halt_ack}, 32'd0);
      check("rst_async.state", {30'd0, state}, 32'd0);
      check("rst_async.stall_cnt", {16'd0, stall_cnt}, 32'd0);
      check("rst_async.flush_cnt", {16'd0, flush_cnt}, 32'd0);
      check_ctl("rst_async", 1'b0, 1'b0, 1'b0, 1'b1);
      halt_req = 1'b0;
      #1;
      rst = 1'b0;
      tick();

      // Saturation on the 2-bit copy: four stalls, then four flushes.
      drive(4'b0010, 3'd2, 3'd5, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0);
      repeat (3) tick();
      check("sat.stall_3", {30'd0, s_stall_cnt}, 32'd3);
      tick();
      check("sat.stall_hold", {30'd0, s_stall_cnt}, 32'd3);
      check("wide.stall_4", {16'd0, stall_cnt}, 32'd4);
      drive(4'b0010, 3'd1, 3'd2, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
      repeat (4) tick();
      check("sat.flush_hold", {30'd0, s_flush_cnt}, 32'd3);
      check("sat.stall_keep", {30'd0, s_stall_cnt}, 32'd3);
      check("wide.flush_4", {16'd0, flush_cnt}, 32'd4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
